// File: rtl/pvr_tex_pkg.sv
// Shared encodings and address widths for the PVR texel fetch path.
package pvr_tex_pkg;

  localparam int WORD_ADDR_W = 29;
  localparam int VRAM_ADDR_W = 23;

  localparam logic [1:0] FMT_16BPP = 2'd0;
  localparam logic [1:0] FMT_8BPP  = 2'd1;
  localparam logic [1:0] FMT_4BPP  = 2'd2;
  localparam logic [1:0] FMT_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // VRAM byte address -> DDR word address; the sum wraps modulo 2^WORD_ADDR_W.
  function automatic logic [WORD_ADDR_W-1:0] word_addr(
    input logic [WORD_ADDR_W-1:0] base,
    input logic [VRAM_ADDR_W-1:0] byte_addr
  );
    return base + {{(WORD_ADDR_W-VRAM_ADDR_W+3){1'b0}}, byte_addr[VRAM_ADDR_W-1:3]};
  endfunction

endpackage

// File: rtl/pvr_texel_extract.sv
// Combinational texel select from a 64-bit word: 16/8/4bpp by byte offset, zero-extended.
import pvr_tex_pkg::*;

module pvr_texel_extract (
  input  logic [63:0] w,
  input  logic [2:0]  o,
  input  logic [1:0]  fmt,
  input  logic        nib,
  output logic [15:0] texel
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = w[{o, 3'b000} +: 8];
    half_sel = w[{o[2:1], 4'b0000} +: 16];
    texel    = half_sel;
    case (fmt)
      FMT_8BPP: texel = {8'd0, byte_sel};
      FMT_4BPP: texel = {12'd0, (nib ? byte_sel[7:4] : byte_sel[3:0])};
      default:  texel = half_sel;   // 16bpp and the reserved code
    endcase
  end

endmodule

// File: rtl/pvr_texel_fetch.sv
// Texel fetch front-end with a one-word line buffer; hit: texel 1 cycle after accept, miss: read pulse 1 cycle after accept.
// One request in flight; texel held until texel_ready. Optional WAIT watchdog under TEXEL_FETCH_TIMEOUT_EN.
import pvr_tex_pkg::*;

module pvr_texel_fetch #(
  parameter logic [WORD_ADDR_W-1:0] VRAM_WORD_BASE = 29'h0400000,
  parameter int                     TIMEOUT_CYCLES = 1023
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [VRAM_ADDR_W-1:0] req_addr,
  input  logic [1:0]             req_fmt,
  input  logic                   req_nib,
  input  logic                   inv_in,
  output logic                   texel_valid,
  input  logic                   texel_ready,
  output logic [15:0]            texel_out,
  output logic [WORD_ADDR_W-1:0] ddram_addr_out,
  output logic                   ddram_rd_out,
  input  logic [63:0]            ddram_readdata_in,
  input  logic                   ddram_valid_in,
  output logic                   fetch_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be positive");
  end

  state_e                 state_q, state_d;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]             off_q, off_d;
  logic [1:0]             fmt_q, fmt_d;
  logic                   nib_q, nib_d;
  logic [63:0]            line_data_q, line_data_d;
  logic [WORD_ADDR_W-1:0] line_tag_q, line_tag_d;
  logic                   line_valid_q, line_valid_d;
  logic                   inv_seen_q, inv_seen_d;
  logic [15:0]            texel_q, texel_d;

  logic [WORD_ADDR_W-1:0] req_waddr;
  logic [63:0]            ext_w;
  logic [2:0]             ext_o;
  logic [1:0]             ext_fmt;
  logic                   ext_nib;
  logic [15:0]            ext_texel;

`ifdef TEXEL_FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign req_waddr      = word_addr(VRAM_WORD_BASE, req_addr);
  assign req_ready      = (state_q == ST_IDLE);
  assign texel_valid    = (state_q == ST_OUT);
  assign ddram_rd_out   = (state_q == ST_REQ);
  assign ddram_addr_out = addr_q;
  assign texel_out      = texel_q;

  // A hit extracts from the buffered word with the live request fields; a fill uses the returned word.
  always_comb begin
    ext_w   = ddram_readdata_in;
    ext_o   = off_q;
    ext_fmt = fmt_q;
    ext_nib = nib_q;
    if (state_q == ST_IDLE) begin
      ext_w   = line_data_q;
      ext_o   = req_addr[2:0];
      ext_fmt = req_fmt;
      ext_nib = req_nib;
    end
  end

  pvr_texel_extract u_extract (
    .w     (ext_w),
    .o     (ext_o),
    .fmt   (ext_fmt),
    .nib   (ext_nib),
    .texel (ext_texel)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    fmt_d        = fmt_q;
    nib_d        = nib_q;
    line_data_d  = line_data_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    inv_seen_d   = inv_seen_q;
    texel_d      = texel_q;
`ifdef TEXEL_FETCH_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_waddr;
          off_d      = req_addr[2:0];
          fmt_d      = req_fmt;
          nib_d      = req_nib;
          inv_seen_d = 1'b0;
          if (line_valid_q && (req_waddr == line_tag_q) && !inv_in) begin
            texel_d = ext_texel;
            state_d = ST_OUT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        inv_seen_d = inv_seen_q | inv_in;
`ifdef TEXEL_FETCH_TIMEOUT_EN
        cnt_d      = '0;
`endif
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (ddram_valid_in) begin
          line_data_d  = ddram_readdata_in;
          line_tag_d   = addr_q;
          // Data read before a VRAM write may be stale; deliver it once but don't keep it.
          line_valid_d = !(inv_seen_q | inv_in);
          texel_d      = ext_texel;
          state_d      = ST_OUT;
        end else begin
          inv_seen_d = inv_seen_q | inv_in;
`ifdef TEXEL_FETCH_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            err_d        = 1'b1;
            texel_d      = 16'h0000;
            line_valid_d = 1'b0;
            state_d      = ST_OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_OUT: begin
        if (texel_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (inv_in) begin
      line_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      off_q        <= '0;
      fmt_q        <= FMT_16BPP;
      nib_q        <= 1'b0;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      inv_seen_q   <= 1'b0;
      texel_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      fmt_q        <= fmt_d;
      nib_q        <= nib_d;
      line_data_q  <= line_data_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      inv_seen_q   <= inv_seen_d;
      texel_q      <= texel_d;
    end
  end

`ifdef TEXEL_FETCH_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_pvr_texel_fetch.sv
// Directed + randomized bench for pvr_texel_fetch against a line-buffer reference model.
module tb_pvr_texel_fetch;

  localparam logic [28:0] BASE = 29'h0400000;
`ifdef TEXEL_FETCH_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1023;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_nib, inv_in;
  logic [22:0] req_addr;
  logic [1:0]  req_fmt;
  logic        texel_valid, texel_ready;
  logic [15:0] texel_out;
  logic [28:0] ddram_addr_out;
  logic        ddram_rd_out, ddram_valid_in, fetch_err;
  logic [63:0] ddram_readdata_in;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;

  // Reference model: one buffered word, valid/tag/data, plus the sticky error flag.
  logic        m_valid = 1'b0;
  logic [28:0] m_tag   = '0;
  logic [63:0] m_data  = '0;
  logic        m_err   = 1'b0;

  pvr_texel_fetch #(.VRAM_WORD_BASE(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_fmt           (req_fmt),
    .req_nib           (req_nib),
    .inv_in            (inv_in),
    .texel_valid       (texel_valid),
    .texel_ready       (texel_ready),
    .texel_out         (texel_out),
    .ddram_addr_out    (ddram_addr_out),
    .ddram_rd_out      (ddram_rd_out),
    .ddram_readdata_in (ddram_readdata_in),
    .ddram_valid_in    (ddram_valid_in),
    .fetch_err         (fetch_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (ddram_rd_out === 1'b1) rd_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_tex(input logic [63:0] w, input logic [2:0] o,
                                        input logic [1:0] f, input logic n);
    logic [63:0] s;
    int unsigned off = o;
    if (f == 2'd1) begin
      s = w >> (off * 8);
      return {8'd0, s[7:0]};
    end else if (f == 2'd2) begin
      s = w >> (off * 8 + (n ? 4 : 0));
      return {12'd0, s[3:0]};
    end
    s = w >> ((off / 2) * 16);
    return s[15:0];
  endfunction

  task automatic do_req(input logic [22:0] a, input logic [1:0] f, input logic n,
                        input logic inv_acc, input logic inv_wait, input logic [63:0] wd,
                        input int hold, input int wlat);
    logic [28:0] wa;
    logic        hit;
    logic [15:0] exp_t;
    int          rd0;
    wa  = BASE + 29'(a >> 3);
    hit = m_valid && (m_tag == wa) && !inv_acc;
    chk("req_ready_idle", req_ready, 1);
    rd0 = rd_cnt;
    req_valid = 1; req_addr = a; req_fmt = f; req_nib = n; inv_in = inv_acc;
    if (inv_acc) m_valid = 0;
    @(negedge clock);
    req_valid = 0; inv_in = 0;
    if (hit) begin
      exp_t = m_tex(m_data, a[2:0], f, n);
      chk("hit_no_rd", 64'(rd_cnt - rd0), 0);
    end else begin
      chk("miss_rd", ddram_rd_out, 1);
      chk("miss_addr", ddram_addr_out, wa);
      chk("miss_not_valid", texel_valid, 0);
      inv_in = inv_wait;
      @(negedge clock);
      inv_in = 0;
      repeat (wlat) begin
        chk("wait_quiet", {ddram_rd_out, texel_valid}, 0);
        @(negedge clock);
      end
      ddram_valid_in = 1; ddram_readdata_in = wd;
      @(negedge clock);
      ddram_valid_in = 0; ddram_readdata_in = {$urandom, $urandom};
      exp_t = m_tex(wd, a[2:0], f, n);
      chk("one_rd", 64'(rd_cnt - rd0), 1);
      m_tag = wa; m_data = wd; m_valid = !inv_wait;
    end
    chk("texel_valid", texel_valid, 1);
    chk("texel", texel_out, exp_t);
    chk("err_flag", fetch_err, m_err);
    rd0 = rd_cnt;
    repeat (hold) begin
      @(negedge clock);
      chk("bp_texel_stable", texel_out, exp_t);
      chk("bp_valid_held", texel_valid, 1);
      chk("bp_not_ready", req_ready, 0);
    end
    chk("bp_no_rd", 64'(rd_cnt - rd0), 0);
    texel_ready = 1;
    @(negedge clock);
    texel_ready = 0;
    chk("out_done", {texel_valid, req_ready}, 2'b01);
  endtask

  initial begin
    reset_n = 0; req_valid = 0; req_addr = '0; req_fmt = '0; req_nib = 0; inv_in = 0;
    texel_ready = 0; ddram_valid_in = 0; ddram_readdata_in = '0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {ddram_rd_out, texel_valid, fetch_err}, 0);
    chk("rst_addr", ddram_addr_out, 0);
    chk("rst_texel", texel_out, 0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // Miss then hit in the same word.
    do_req(23'h000010, 2'd0, 0, 0, 0, 64'h4444_3333_2222_1111, 0, 0);
    chk("plan_word_addr", m_tag, 29'h0400002);
    do_req(23'h000016, 2'd0, 0, 0, 0, 64'h0, 0, 0);

    // Stray valid while idle must not disturb the buffered word.
    ddram_valid_in = 1; ddram_readdata_in = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clock);
    ddram_valid_in = 0;
    do_req(23'h000012, 2'd0, 0, 0, 0, 64'h0, 0, 0);

    // 8bpp / 4bpp extraction.
    do_req(23'h000103, 2'd1, 0, 0, 0, 64'hF7E6D5C4B3A29180, 0, 2);
    chk("plan_8bpp", texel_out, 16'h00B3);
    do_req(23'h000103, 2'd2, 1, 0, 0, 64'h0, 0, 0);
    chk("plan_4bpp_hi", texel_out, 16'h000B);
    do_req(23'h000103, 2'd2, 0, 0, 0, 64'h0, 0, 0);
    chk("plan_4bpp_lo", texel_out, 16'h0003);
    do_req(23'h000107, 2'd3, 0, 0, 0, 64'h0, 0, 0);

    // Backpressure: consumer stalls 5 cycles.
    do_req(23'h000105, 2'd1, 0, 0, 0, 64'h0, 5, 0);

    // Invalidate on accept of the cached word -> miss.
    do_req(23'h000101, 2'd1, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 0, 1);
    // Invalidate during WAIT -> delivered but not kept; same word then misses.
    do_req(23'h000200, 2'd0, 0, 0, 1, 64'h1357_9BDF_2468_ACE0, 1, 2);
    do_req(23'h000202, 2'd0, 0, 0, 0, 64'h1111_2222_3333_4444, 0, 0);

    // Randomized traffic over a few neighbouring words.
    for (int i = 0; i < 40; i++) begin
      logic [19:0] idx;
      logic [2:0]  o;
      idx = 20'h40 + 20'($urandom_range(0, 3));
      o   = 3'($urandom_range(0, 7));
      do_req({idx, o}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
             {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while waiting on the cache.
    do_req(23'h000300, 2'd0, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    req_valid = 1; req_addr = 23'h000400; req_fmt = 2'd0;
    @(negedge clock);
    req_valid = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 0;
    #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_outs", {ddram_rd_out, texel_valid, fetch_err}, 0);
    chk("rst_mid_addr", ddram_addr_out, 0);
    chk("rst_mid_texel", texel_out, 0);
    m_valid = 0; m_err = 0;
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    do_req(23'h000302, 2'd0, 0, 0, 0, 64'h5555_6666_7777_8888, 0, 0);

`ifdef TEXEL_FETCH_TIMEOUT_EN
    begin
      int rd0;
      rd0 = rd_cnt;
      req_valid = 1; req_addr = 23'h000500; req_fmt = 2'd0; req_nib = 0;
      @(negedge clock);
      req_valid = 0;
      chk("tmo_rd", ddram_rd_out, 1);
      for (int c = 0; c < TMO; c++) begin
        @(negedge clock);
        chk("tmo_waiting", {texel_valid, fetch_err}, 0);
      end
      @(negedge clock);
      m_err = 1; m_valid = 0;
      chk("tmo_valid", texel_valid, 1);
      chk("tmo_texel", texel_out, 0);
      chk("tmo_err", fetch_err, 1);
      ddram_valid_in = 1; ddram_readdata_in = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clock);
      ddram_valid_in = 0;
      chk("tmo_late_ignored", texel_out, 0);
      chk("tmo_one_rd", 64'(rd_cnt - rd0), 1);
      texel_ready = 1;
      @(negedge clock);
      texel_ready = 0;
      do_req(23'h000500, 2'd0, 0, 0, 0, 64'h9999_8888_7777_6666, 0, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pvr_texel_fetch.md
Name: pvr_texel_fetch

Overview:
- Texel fetch front-end for the PVR texture path; sits directly upstream of the 8-word DDR read cache.
- Accepts one texel request at a time (VRAM byte address + format) and issues a single 64-bit word read to the cache.
- Extracts the 4/8/16-bit texel from the returned word and presents it zero-extended to 16 bits.
- Holds the last fetched word in a one-entry line buffer, so repeat hits to the same word skip the cache entirely.

Parameters:
- VRAM_WORD_BASE, 29'h0400000, DDR word address of VRAM byte 0. Added to the word index modulo 2^29.
- TIMEOUT_CYCLES, 1023, WAIT-state watchdog limit. Used only with TEXEL_FETCH_TIMEOUT_EN.

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  texel request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  23  VRAM byte address
- req_fmt  in  2  0=16bpp, 1=8bpp, 2=4bpp, 3=reserved (treated as 16bpp)
- req_nib  in  1  4bpp nibble select: 0=low [3:0], 1=high [7:4]
- inv_in  in  1  invalidate line buffer (VRAM written)
- texel_valid  out  1  texel available
- texel_ready  in  1  consumer takes texel
- texel_out  out  16  zero-extended texel
- ddram_addr_out  out  29  word address to cache
- ddram_rd_out  out  1  one-cycle read pulse to cache
- ddram_readdata_in  in  64  word from cache
- ddram_valid_in  in  1  word valid from cache
- fetch_err  out  1  sticky timeout flag (tied 0 without the macro)

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, ddram_rd_out=0, ddram_addr_out=0, texel_valid=0, texel_out=0, line_valid=0, fetch_err=0.
- req_ready = (state==IDLE), combinational. It is 1 while reset is held.
- Word address = VRAM_WORD_BASE + {9'd0, req_addr[22:3]}, mod 2^29.
- Latched on accept: word address, req_addr[2:0], fmt, nib.
- States:
  - IDLE: on accept, hit (line_valid && latched word addr == line_tag && !inv_in) -> OUT. Otherwise -> REQ.
  - REQ (1 cycle): drive ddram_addr_out, pulse ddram_rd_out=1 -> WAIT.
  - WAIT: on ddram_valid_in, capture line_data and line_tag, set line_valid=1 unless an invalidate occurred since REQ -> OUT.
  - OUT: texel_valid=1. Hold texel_out stable until texel_ready; then texel_valid=0 -> IDLE.
- Texel computation: texel_out is registered on entry to OUT.
- Extraction, with word w and byte offset o = addr[2:0]:
  - 16bpp: w[o[2:1]*16 +: 16]; o[0] ignored.
  - 8bpp: {8'd0, w[o*8 +: 8]}.
  - 4bpp: {12'd0, nib ? w[o*8+4 +: 4] : w[o*8 +: 4]}.
- Latency:
  - hit: texel_valid asserts the cycle after accept.
  - miss: ddram_rd_out asserts the cycle after accept; texel_valid asserts the cycle after ddram_valid_in.
- Exactly one read in flight; ddram_rd_out never asserts outside REQ.
- ddram_valid_in outside WAIT is ignored.
- inv_in clears line_valid in any state. When inv_in coincides with an accept, the request is treated as a miss. Invalidation during WAIT: data is still delivered to the consumer but is not retained.
- Back-to-back different words inside the same 8-word cache line go to the cache; its own hit logic applies.

Optional Feature:
- Macro: TEXEL_FETCH_TIMEOUT_EN.
- With it: a WAIT counter (10+ bits, sized from TIMEOUT_CYCLES) resets on entering WAIT. On reaching TIMEOUT_CYCLES without ddram_valid_in:
  - set fetch_err=1 (sticky until reset);
  - texel_out=16'h0000, line_valid=0 -> OUT.
  A late ddram_valid_in is then ignored.
- Without it: no counter; WAIT waits indefinitely; fetch_err is constant 0.

Decomposition:
- Package pvr_tex_pkg: format encoding constants (FMT_16BPP/8BPP/4BPP), state encoding, WORD_ADDR_W=29, VRAM_ADDR_W=23.
- Sub-module pvr_texel_extract: combinational (w, o, fmt, nib) -> 16-bit texel, reused by the future palette stage.

Test Plan:
- Miss then hit:
  - req addr 23'h000010, fmt 16bpp, cache returns 64'h4444_3333_2222_1111 -> ddram_addr_out=29'h0400002, one rd pulse, texel 16'h1111.
  - Then addr 23'h000016 -> no rd pulse, texel 16'h4444 the cycle after accept.
- 8bpp/4bpp extraction: word 64'hF7E6D5C4B3A29180:
  - addr o=3, 8bpp -> 16'h00B3.
  - o=3, 4bpp nib=1 -> 16'h000B; nib=0 -> 16'h0003.
- Backpressure: hold texel_ready=0 for 5 cycles -> texel_out stable, req_ready=0, no new rd pulse.
- Invalidate:
  - inv_in in the same cycle as accept of the cached word -> treated as a miss, rd issued.
  - inv_in during WAIT -> texel delivered; next same-word request misses.
- Reset mid-WAIT: assert reset_n=0 during WAIT -> all outputs at reset values, line_valid=0. First post-reset request misses.
- Timeout (macro on, TIMEOUT_CYCLES=16): no ddram_valid_in -> after 16 WAIT cycles, texel 16'h0000 and fetch_err=1. A late valid is ignored.
